// File: rtl/tensor_pkg.sv
// Shared constants for the tensor/vector command path:
// opcodes, command field positions and the issue state encoding.
package tensor_pkg;

  localparam logic [7:0] OP_VPU = 8'h02;

  localparam logic [7:0] VOP_LOAD  = 8'h30;
  localparam logic [7:0] VOP_STORE = 8'h31;
  localparam logic [7:0] VOP_ADD   = 8'h40;
  localparam logic [7:0] VOP_MUL   = 8'h41;

  localparam int OPC_MSB = 127;
  localparam int OPC_LSB = 120;
  localparam int SUB_MSB = 119;
  localparam int SUB_LSB = 112;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } issue_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy, synchronous flush
// and asynchronous active-high reset.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  // Flush wins over any pointer movement in the same cycle
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop)
        count_d = count_q + (AW+1)'(1);
      else if (do_pop && !do_push)
        count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/vpu_cmd_queue.sv
// Opcode filter, command FIFO and one-outstanding issue stage
// feeding vector_unit.
module vpu_cmd_queue
  import tensor_pkg::*;
#(
  parameter int         CMD_WIDTH  = 128,
  parameter int         DEPTH      = 8,
  parameter logic [7:0] VPU_OPCODE = OP_VPU,
  localparam int        CW         = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_WIDTH-1:0] in_cmd,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [CMD_WIDTH-1:0] vpu_cmd,
  output logic                 vpu_cmd_valid,
  input  logic                 vpu_cmd_ready,
  input  logic                 vpu_cmd_done,
  output logic [CW-1:0]        count,
  output logic                 idle,
  output logic                 bad_opcode,
  output logic [7:0]           bad_count
);

  issue_state_e         state_q, state_d;
  logic [CMD_WIDTH-1:0] issue_q, issue_d;
  logic                 bad_opcode_q, bad_opcode_d;
  logic [7:0]           bad_count_q, bad_count_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 fifo_push;
  logic [CMD_WIDTH-1:0] fifo_rdata;
  logic                 accept;
  logic                 opc_ok;

  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;
  assign opc_ok    = (in_cmd[OPC_MSB:OPC_LSB] == VPU_OPCODE);
  assign fifo_push = accept && opc_ok;

  sync_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (fifo_push),
    .wdata (in_cmd),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    bad_opcode_d = accept && !opc_ok;
    bad_count_d  = bad_count_q;
    if (bad_opcode_d && bad_count_q != 8'hFF)
      bad_count_d = bad_count_q + 8'd1;
  end

  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          issue_d  = fifo_rdata;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (vpu_cmd_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (vpu_cmd_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issue_q      <= '0;
      bad_opcode_q <= 1'b0;
      bad_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      issue_q      <= issue_d;
      bad_opcode_q <= bad_opcode_d;
      bad_count_q  <= bad_count_d;
    end
  end

  assign vpu_cmd       = issue_q;
  assign vpu_cmd_valid = (state_q == ST_ISSUE);
  assign idle          = fifo_empty && (state_q == ST_IDLE);
  assign bad_opcode    = bad_opcode_q;
  assign bad_count     = bad_count_q;

endmodule

// File: tb/tb_vpu_cmd_queue.sv
// Directed bench for vpu_cmd_queue with an issue-order scoreboard
// checked at every command acceptance.
module tb_vpu_cmd_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_cmd;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [127:0] vpu_cmd;
  logic         vpu_cmd_valid;
  logic         vpu_cmd_ready;
  logic         vpu_cmd_done;
  logic [3:0]   count;
  logic         idle;
  logic         bad_opcode;
  logic [7:0]   bad_count;

  int total = 0;
  int bad   = 0;
  int accepts = 0;
  logic [7:0]   sb[$];
  logic [127:0] word;
  int a0;

  vpu_cmd_queue #(
    .CMD_WIDTH  (128),
    .DEPTH      (8),
    .VPU_OPCODE (8'h02)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_cmd        (in_cmd),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flush         (flush),
    .vpu_cmd       (vpu_cmd),
    .vpu_cmd_valid (vpu_cmd_valid),
    .vpu_cmd_ready (vpu_cmd_ready),
    .vpu_cmd_done  (vpu_cmd_done),
    .count         (count),
    .idle          (idle),
    .bad_opcode    (bad_opcode),
    .bad_count     (bad_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] op,
                                      input logic [7:0] sub);
    return {op, sub, 80'h0, 24'hC0FFEE, sub};
  endfunction

  // Drive one word for one edge; good opcodes go to the scoreboard
  task automatic push(input logic [7:0] op, input logic [7:0] sub);
    in_cmd   = mk(op, sub);
    in_valid = 1'b1;
    if (op == 8'h02 && !flush) sb.push_back(sub);
    tick();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && vpu_cmd_valid && vpu_cmd_ready) begin
      logic [7:0] e;
      accepts++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL issue_unexpected observed=%0h expected=none",
               vpu_cmd[119:112]);
      end else begin
        e = sb.pop_front();
        assert (vpu_cmd[119:112] === e) else begin
          bad++;
          $error("FAIL issue_order observed=%0h expected=%0h",
                 vpu_cmd[119:112], e);
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    in_cmd        = '0;
    in_valid      = 1'b0;
    flush         = 1'b0;
    vpu_cmd_ready = 1'b0;
    vpu_cmd_done  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset values
    chk("rst_valid", 128'(vpu_cmd_valid), 128'd0);
    chk("rst_cmd", vpu_cmd, 128'd0);
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_idle", 128'(idle), 128'd1);
    chk("rst_bad_opc", 128'(bad_opcode), 128'd0);
    chk("rst_bad_cnt", 128'(bad_count), 128'd0);

    // single VOP_LOAD, ready held high
    vpu_cmd_ready = 1'b1;
    push(8'h02, 8'h30);
    chk("t1_count_e", 128'(count), 128'd1);
    chk("t1_valid_e", 128'(vpu_cmd_valid), 128'd0);
    tick();
    chk("t1_valid_e1", 128'(vpu_cmd_valid), 128'd1);
    chk("t1_subop", 128'(vpu_cmd[119:112]), 128'h30);
    chk("t1_idle_e1", 128'(idle), 128'd0);
    tick();
    chk("t1_valid_e2", 128'(vpu_cmd_valid), 128'd0);
    chk("t1_idle_e2", 128'(idle), 128'd0);
    tick();
    chk("t1_idle_wait", 128'(idle), 128'd0);
    vpu_cmd_done = 1'b1;
    tick();
    vpu_cmd_done = 1'b0;
    chk("t1_idle_done", 128'(idle), 128'd1);
    chk("t1_valid_done", 128'(vpu_cmd_valid), 128'd0);

    // fill while stalled
    vpu_cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h02, 8'(8'h40 + i));
    chk("t2_count_full", 128'(count), 128'd8);
    chk("t2_in_ready", 128'(in_ready), 128'd0);
    chk("t2_valid", 128'(vpu_cmd_valid), 128'd1);
    chk("t2_head", 128'(vpu_cmd[119:112]), 128'h40);
    in_cmd   = mk(8'h02, 8'hEE);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t2_full_drop", 128'(count), 128'd8);
    vpu_cmd_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t2_wait_valid", 128'(vpu_cmd_valid), 128'd0);
      vpu_cmd_done = 1'b1;
      tick();
      vpu_cmd_done = 1'b0;
      tick();
      chk("t2_next_valid", 128'(vpu_cmd_valid), 128'(i < 8));
      chk("t2_drain_cnt", 128'(count), 128'(i < 8 ? 7 - i : 0));
    end
    chk("t2_sb_empty", 128'(sb.size()), 128'd0);
    chk("t2_idle", 128'(idle), 128'd1);

    // bad opcode filter and saturation
    push(8'h05, 8'h30);
    chk("t3_bad_pulse", 128'(bad_opcode), 128'd1);
    chk("t3_bad_cnt", 128'(bad_count), 128'd1);
    chk("t3_count", 128'(count), 128'd0);
    tick();
    chk("t3_bad_fall", 128'(bad_opcode), 128'd0);
    chk("t3_no_issue", 128'(vpu_cmd_valid), 128'd0);
    in_cmd   = mk(8'h05, 8'h11);
    in_valid = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    tick();
    chk("t3_bad_sat", 128'(bad_count), 128'd255);
    chk("t3_sat_count", 128'(count), 128'd0);

    // flush during WAIT_DONE with three queued
    vpu_cmd_ready = 1'b1;
    push(8'h02, 8'h50);
    push(8'h02, 8'h51);
    push(8'h02, 8'h52);
    push(8'h02, 8'h53);
    chk("t4_count3", 128'(count), 128'd3);
    chk("t4_waiting", 128'(vpu_cmd_valid), 128'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    chk("t4_flushed", 128'(count), 128'd0);
    chk("t4_inflight", 128'(vpu_cmd[119:112]), 128'h50);
    vpu_cmd_done = 1'b1;
    tick();
    vpu_cmd_done = 1'b0;
    chk("t4_idle", 128'(idle), 128'd1);
    tick();
    tick();
    chk("t4_no_issue", 128'(vpu_cmd_valid), 128'd0);

    // backpressure during ISSUE
    vpu_cmd_ready = 1'b0;
    word = mk(8'h02, 8'h60);
    push(8'h02, 8'h60);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold_valid", 128'(vpu_cmd_valid), 128'd1);
      chk("t5_hold_cmd", vpu_cmd, word);
      tick();
    end
    a0 = accepts;
    vpu_cmd_ready = 1'b1;
    tick();
    chk("t5_valid_fall", 128'(vpu_cmd_valid), 128'd0);
    chk("t5_one_accept", 128'(accepts - a0), 128'd1);
    vpu_cmd_done = 1'b1;
    tick();
    vpu_cmd_done = 1'b0;

    // reset during WAIT_DONE
    push(8'h02, 8'h70);
    tick();
    tick();
    push(8'h02, 8'h71);
    chk("t6_pre_count", 128'(count), 128'd1);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("t6_async_count", 128'(count), 128'd0);
    chk("t6_async_cmd", vpu_cmd, 128'd0);
    chk("t6_async_ready", 128'(in_ready), 128'd1);
    tick();
    rst = 1'b0;
    vpu_cmd_done = 1'b1;
    tick();
    vpu_cmd_done = 1'b0;
    chk("t6_idle", 128'(idle), 128'd1);
    chk("t6_valid", 128'(vpu_cmd_valid), 128'd0);
    chk("t6_cmd", vpu_cmd, 128'd0);
    chk("t6_bad_cnt", 128'(bad_count), 128'd0);
    chk("t6_bad_opc", 128'(bad_opcode), 128'd0);
    tick();
    tick();
    chk("t6_still_idle", 128'(idle), 128'd1);
    chk("t6_no_issue", 128'(vpu_cmd_valid), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
